// File: rtl/rvfi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rvfi_mem_arbiter
//
// Two-requester arbiter for the picorv32 native memory interface. Two masters
// (e.g. a core under test and a second core or DMA model) share one memory
// port. The grant is round-robin, decided in IDLE (one cycle of arbitration
// latency) and held for the whole transfer. A wait-state watchdog raises a
// sticky timeout flag when the slave stalls too long.
//
// Optional feature (compile-time macro RVFI_MEMARB_IFETCH_PRIO_EN):
//   when defined, an instruction fetch beats a data access if both masters
//   request in the same IDLE cycle; equal instr flags fall back to
//   round-robin. When undefined, arbitration is pure round-robin and the
//   instr flags only pass through to s_instr.
//
// Parameters:
//   MAX_WAIT  BUSY cycles without s_ready before timeout is set (1..255)
//   CNT_W     width of the wait counter, must hold MAX_WAIT
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   m0_* / m1_*                 master ports: valid, instr, addr, wdata,
//                               wstrb (0 = read) in; ready, rdata out
//   s_*                         shared slave port: valid, instr, addr,
//                               wdata, wstrb out; ready, rdata in
//   owner                       current or last granted master
//   busy                        high while a transfer is in progress
//   timeout                     sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module rvfi_mem_arbiter #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic        owner,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] wait_cnt;

  logic             pick;        // winner if a grant happens this IDLE cycle
  logic             owner_valid; // owner's request, used to detect a dropped valid

  // Winner selection. Only meaningful when at least one master is valid.
  always_comb begin
    // NOTE: default assignment first so every path writes pick; without it
    // the missing else-branches would infer a latch.
    pick = 1'b0;
    if (m0_valid && m1_valid) begin
`ifdef RVFI_MEMARB_IFETCH_PRIO_EN
      if (m0_instr != m1_instr)
        pick = m1_instr;          // the fetching master wins
      else
        pick = ~last_grant;
`else
      pick = ~last_grant;
`endif
    end else if (m1_valid) begin
      pick = 1'b1;
    end
  end

  assign owner_valid = owner ? m1_valid : m0_valid;
  assign busy        = (state == BUSY);

  // The shared port follows the owner combinationally; s_valid is gated by
  // BUSY so nothing reaches the slave during the arbitration cycle.
  assign s_valid = busy && owner_valid;
  assign s_instr = owner ? m1_instr : m0_instr;
  assign s_addr  = owner ? m1_addr  : m0_addr;
  assign s_wdata = owner ? m1_wdata : m0_wdata;
  assign s_wstrb = owner ? m1_wstrb : m0_wstrb;

  // Ready is a pass-through of s_ready to the owner only. Gating with the
  // owner's valid keeps a dropped request from ever seeing a ready pulse.
  assign m0_ready = busy && !owner && m0_valid && s_ready;
  assign m1_ready = busy &&  owner && m1_valid && s_ready;

  // Read data is broadcast; each master qualifies it with its own ready.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  // last_grant resets to 1 so master 0 wins the first contested arbitration.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      timeout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // sees the pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (m0_valid || m1_valid) begin
            owner <= pick;
            state <= BUSY;
          end
        end

        BUSY: begin
          if (!owner_valid) begin
            // Protocol violation: abandon without touching the rotation.
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (s_ready) begin
            state      <= IDLE;
            last_grant <= owner;
            wait_cnt   <= '0;
          end else begin
            if (wait_cnt < MAX_WAIT_C)
              wait_cnt <= wait_cnt + ONE_C;
            // Flag on the same edge the counter reaches MAX_WAIT; the
            // transfer itself keeps waiting.
            if (wait_cnt >= MAX_WAIT_C - ONE_C)
              timeout <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rvfi_mem_arbiter
//
// Directed self-checking bench for rvfi_mem_arbiter (MAX_WAIT overridden to
// 4). Inputs change 1 ns after the rising edge and outputs are sampled a
// further 2 ns later, well clear of the active edge. Expected values are
// hand-derived from the arbiter's intended behaviour.
// ---------------------------------------------------------------------------
module tb_rvfi_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;

  logic        m0_valid, m0_instr;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ready;
  logic [31:0] m0_rdata;

  logic        m1_valid, m1_instr;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ready;
  logic [31:0] m1_rdata;

  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  logic        owner, busy, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  rvfi_mem_arbiter #(.MAX_WAIT(4), .CNT_W(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .m0_valid (m0_valid),
    .m0_instr (m0_instr),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_wstrb (m0_wstrb),
    .m0_ready (m0_ready),
    .m0_rdata (m0_rdata),
    .m1_valid (m1_valid),
    .m1_instr (m1_instr),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_wstrb (m1_wstrb),
    .m1_ready (m1_ready),
    .m1_rdata (m1_rdata),
    .s_valid  (s_valid),
    .s_instr  (s_instr),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .owner    (owner),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    #3;
    // ---------------- reset state ----------------
    check("rst_s_valid",  32'(s_valid),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_m0_ready", 32'(m0_ready), 32'd0);
    check("rst_m1_ready", 32'(m1_ready), 32'd0);
    check("rst_owner",    32'(owner),    32'd0);
    check("rst_timeout",  32'(timeout),  32'd0);
    step();
    step();
    resetn = 1'b1;

    // ---------------- T1: m0 read, s_ready on 3rd BUSY cycle ----------------
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    settle();
    check("t1_idle_s_valid", 32'(s_valid), 32'd0);
    check("t1_idle_busy",    32'(busy),    32'd0);
    step(); settle();                                  // BUSY cycle 1
    check("t1_busy",    32'(busy),    32'd1);
    check("t1_s_valid", 32'(s_valid), 32'd1);
    check("t1_s_addr",  s_addr,       32'h100);
    check("t1_owner",   32'(owner),   32'd0);
    check("t1_m0_ready_c1", 32'(m0_ready), 32'd0);
    step(); settle();                                  // BUSY cycle 2
    check("t1_m0_ready_c2", 32'(m0_ready), 32'd0);
    step();                                            // BUSY cycle 3
    s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
    settle();
    check("t1_m0_ready_c3", 32'(m0_ready), 32'd1);
    check("t1_m0_rdata",    m0_rdata,      32'hDEADBEEF);
    check("t1_m1_ready",    32'(m1_ready), 32'd0);
    step();
    m0_valid = 1'b0; s_ready = 1'b0;
    settle();
    check("t1_done_busy",     32'(busy),     32'd0);
    check("t1_done_m0_ready", 32'(m0_ready), 32'd0);
    check("t1_done_owner",    32'(owner),    32'd0);

    // ---------------- T2: both valid, alternating grants ----------------
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h10;
    m1_valid = 1'b1; m1_addr = 32'h20;
    s_ready  = 1'b1;                                   // ignored while IDLE
    settle();
    check("t2_idle_m0_ready", 32'(m0_ready), 32'd0);
    check("t2_idle_busy",     32'(busy),     32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_own;
      exp_own = (i % 2 == 0) ? 32'd0 : 32'd1;
      step(); settle();
      check($sformatf("t2_owner_%0d", i),    32'(owner),    exp_own);
      check($sformatf("t2_s_addr_%0d", i),   s_addr,        (i % 2 == 0) ? 32'h10 : 32'h20);
      check($sformatf("t2_m0_ready_%0d", i), 32'(m0_ready), 32'd1 - exp_own);
      check($sformatf("t2_m1_ready_%0d", i), 32'(m1_ready), exp_own);
      step(); settle();
      check($sformatf("t2_gap_busy_%0d", i), 32'(busy), 32'd0);
    end
    idle_inputs();

    // ---------------- T3: m1 write, then last_grant=1 gives m0 next ----------
    do_reset();
    m1_valid = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h12345678; m1_wstrb = 4'h3;
    step();
    s_ready = 1'b1;
    settle();
    check("t3_owner",    32'(owner),    32'd1);
    check("t3_s_addr",   s_addr,        32'h200);
    check("t3_s_wdata",  s_wdata,       32'h12345678);
    check("t3_s_wstrb",  32'(s_wstrb),  32'h3);
    check("t3_m1_ready", 32'(m1_ready), 32'd1);
    check("t3_m0_ready", 32'(m0_ready), 32'd0);
    step();
    s_ready = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h300;                // both now valid
    settle();
    check("t3_gap_m1_ready", 32'(m1_ready), 32'd0);
    step(); settle();
    check("t3_next_owner", 32'(owner), 32'd0);
    idle_inputs();

    // ---------------- T4: watchdog with MAX_WAIT=4 ----------------
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h400;
    step();                                            // BUSY cycle 1
    for (int k = 1; k <= 5; k++) begin
      step(); settle();
      check($sformatf("t4_timeout_%0d", k), 32'(timeout), (k >= 4) ? 32'd1 : 32'd0);
      check($sformatf("t4_busy_%0d", k),    32'(busy),    32'd1);
    end
    #(-2 + 2);
    s_ready = 1'b1;
    settle();
    check("t4_m0_ready", 32'(m0_ready), 32'd1);
    step();
    m0_valid = 1'b0; s_ready = 1'b0;
    settle();
    check("t4_after_busy",    32'(busy),    32'd0);
    check("t4_after_timeout", 32'(timeout), 32'd1);
    resetn = 1'b0;
    #1;
    check("t4_reset_timeout", 32'(timeout), 32'd0);
    step();
    resetn = 1'b1;

    // ---------------- T5: async reset mid-transfer ----------------
    m0_valid = 1'b1; m0_addr = 32'h500;
    step();
    s_ready = 1'b1;
    settle();
    check("t5_pre_m0_ready", 32'(m0_ready), 32'd1);
    resetn = 1'b0;
    #1;
    check("t5_rst_s_valid",  32'(s_valid),  32'd0);
    check("t5_rst_busy",     32'(busy),     32'd0);
    check("t5_rst_m0_ready", 32'(m0_ready), 32'd0);
    step();
    s_ready = 1'b0;
    m1_valid = 1'b1;
    resetn = 1'b1;
    step(); settle();
    check("t5_first_owner", 32'(owner), 32'd0);
    check("t5_first_busy",  32'(busy),  32'd1);
    idle_inputs();

    // ---------------- T6: owner drops valid, rotation untouched ----------------
    do_reset();
    m0_valid = 1'b1;
    step();
    m0_valid = 1'b0; s_ready = 1'b1;
    settle();
    check("t6_drop_m0_ready", 32'(m0_ready), 32'd0);
    step();
    s_ready = 1'b0;
    settle();
    check("t6_drop_busy", 32'(busy), 32'd0);
    m0_valid = 1'b1; m1_valid = 1'b1;
    step(); settle();
    check("t6_owner_after_drop", 32'(owner), 32'd0);
    idle_inputs();

    // ---------------- T7: ifetch priority option ----------------
    // last_grant=1 after reset: m0 data vs m1 fetch.
    do_reset();
    m0_valid = 1'b1; m0_instr = 1'b0;
    m1_valid = 1'b1; m1_instr = 1'b1;
    step(); settle();
`ifdef RVFI_MEMARB_IFETCH_PRIO_EN
    check("t7a_owner",   32'(owner),   32'd1);
    check("t7a_s_instr", 32'(s_instr), 32'd1);
`else
    check("t7a_owner",   32'(owner),   32'd0);
    check("t7a_s_instr", 32'(s_instr), 32'd0);
`endif
    idle_inputs();
    // last_grant=0 after an m0 completion: m0 fetch vs m1 data.
    do_reset();
    m0_valid = 1'b1;
    step();
    s_ready = 1'b1;
    step();
    s_ready = 1'b0;
    m0_valid = 1'b1; m0_instr = 1'b1;
    m1_valid = 1'b1; m1_instr = 1'b0;
    step(); settle();
`ifdef RVFI_MEMARB_IFETCH_PRIO_EN
    check("t7b_owner", 32'(owner), 32'd0);
`else
    check("t7b_owner", 32'(owner), 32'd1);
`endif
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
